// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipe_ctrl_pkg
// Brief  : Shared state encoding and stall-bus bit positions for pipe_ctrl.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_FREEZE = 2'd1,
        CTRL_FLUSH  = 2'd2
    } ctrl_state_e;

    typedef logic [4:0] stall_bus_t;

    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;

    localparam stall_bus_t STALL_NONE   = 5'b00000;
    localparam stall_bus_t STALL_FETCH  = 5'b00001;
    localparam stall_bus_t STALL_BUBBLE = 5'b00011;
    localparam stall_bus_t STALL_ALL    = 5'b11111;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipe_ctrl_if
// Brief  : Hazard inputs and stall/flush outputs of the pipeline controller.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic             ex_branch_taken_i;
    logic [31:0]      ex_branch_target_i;
    logic             ex_is_load_i;
    logic [4:0]       ex_wd_i;
    logic             id_reg1_read_i;
    logic [4:0]       id_reg1_addr_i;
    logic             id_reg2_read_i;
    logic [4:0]       id_reg2_addr_i;
    logic             mem_busy_i;
    logic             if_busy_i;
    stall_bus_t       stall_o;
    logic             IFID_discard_o;
    logic             IDEX_discard_o;
    logic             pc_redirect_o;
    logic [31:0]      pc_target_o;
    logic [CNT_W-1:0] stall_cycles_o;

    modport master (
        output ex_branch_taken_i, ex_branch_target_i, ex_is_load_i, ex_wd_i,
               id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
               mem_busy_i, if_busy_i,
        input  stall_o, IFID_discard_o, IDEX_discard_o, pc_redirect_o,
               pc_target_o, stall_cycles_o
    );

    modport slave (
        input  ex_branch_taken_i, ex_branch_target_i, ex_is_load_i, ex_wd_i,
               id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
               mem_busy_i, if_busy_i,
        output stall_o, IFID_discard_o, IDEX_discard_o, pc_redirect_o,
               pc_target_o, stall_cycles_o
    );

endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_hazard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipe_ctrl_hazard
// Brief  : Load-use hazard compare between EX destination and ID sources.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pipe_ctrl_hazard (
    input  wire logic       ex_is_load,
    input  wire logic [4:0] ex_wd,
    input  wire logic       reg1_read,
    input  wire logic [4:0] reg1_addr,
    input  wire logic       reg2_read,
    input  wire logic [4:0] reg2_addr,
    output logic            load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        load_use = ex_is_load && (ex_wd != 5'd0) &&
                   ((reg1_read && (reg1_addr == ex_wd)) ||
                    (reg2_read && (reg2_addr == ex_wd)));
    end

endmodule : pipe_ctrl_hazard
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipe_ctrl
// Brief  : Pipeline hazard/flush controller (freeze, redirect, bubble, fetch wait).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  bus
);

    localparam logic [2:0] C_FLUSH_INIT = 3'(FLUSH_DEPTH - 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic             r_pend_valid;
    logic             w_pend_valid_nxt;
    logic [31:0]      r_pend_target;
    logic [31:0]      w_pend_target_nxt;
    logic [2:0]       r_flush_cnt;
    logic [2:0]       w_flush_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_load_use;
    logic             w_take_redirect;
    logic [31:0]      w_redirect_target;
    logic             w_eval_idle;
    stall_bus_t       w_stall;
    logic             w_ifid_discard;
    logic             w_idex_discard;
    logic             w_pc_redirect;
    logic [31:0]      w_pc_target;

    pipe_ctrl_hazard u_hazard (
        .ex_is_load (bus.ex_is_load_i),
        .ex_wd      (bus.ex_wd_i),
        .reg1_read  (bus.id_reg1_read_i),
        .reg1_addr  (bus.id_reg1_addr_i),
        .reg2_read  (bus.id_reg2_read_i),
        .reg2_addr  (bus.id_reg2_addr_i),
        .load_use   (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= CTRL_RUN;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_flush_cnt   <= 3'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_take_redirect   = 1'b0;
        w_redirect_target = 32'd0;
        w_eval_idle       = 1'b0;
        w_stall           = STALL_NONE;
        w_ifid_discard    = 1'b0;
        w_idex_discard    = 1'b0;
        w_pc_redirect     = 1'b0;
        w_pc_target       = 32'd0;

        case (r_state)
            CTRL_RUN: begin
                if (bus.mem_busy_i) begin
                    w_stall     = STALL_ALL;
                    w_state_nxt = CTRL_FREEZE;
                    if (bus.ex_branch_taken_i) begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_target_nxt = bus.ex_branch_target_i;
                    end
                end else if (bus.ex_branch_taken_i) begin
                    w_take_redirect   = 1'b1;
                    w_redirect_target = bus.ex_branch_target_i;
                end else begin
                    w_eval_idle = 1'b1;
                end
            end
            CTRL_FREEZE: begin
                if (bus.mem_busy_i) begin
                    w_stall = STALL_ALL;
                    // A held branch was already captured; only the first one counts
                    if (!r_pend_valid && bus.ex_branch_taken_i) begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_target_nxt = bus.ex_branch_target_i;
                    end
                end else begin
                    w_state_nxt = CTRL_RUN;
                    if (r_pend_valid) begin
                        w_take_redirect   = 1'b1;
                        w_redirect_target = r_pend_target;
                        w_pend_valid_nxt  = 1'b0;
                    end else begin
                        w_eval_idle = 1'b1;
                    end
                end
            end
            CTRL_FLUSH: begin
                if (bus.mem_busy_i) begin
                    w_stall = STALL_ALL;
                end else begin
                    w_ifid_discard  = 1'b1;
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    if (r_flush_cnt <= 3'd1) begin
                        w_state_nxt = CTRL_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = CTRL_RUN;
            end
        endcase

        if (w_take_redirect) begin
            w_pc_redirect  = 1'b1;
            w_pc_target    = w_redirect_target;
            w_ifid_discard = 1'b1;
            w_idex_discard = 1'b1;
            if (FLUSH_DEPTH == 1) begin
                w_state_nxt     = CTRL_RUN;
                w_flush_cnt_nxt = 3'd0;
            end else begin
                w_state_nxt     = CTRL_FLUSH;
                w_flush_cnt_nxt = C_FLUSH_INIT;
            end
        end

        if (w_eval_idle) begin
            if (w_load_use) begin
                w_stall        = STALL_BUBBLE;
                w_idex_discard = 1'b1;
            end else if (bus.if_busy_i) begin
                w_stall        = STALL_FETCH;
                w_ifid_discard = 1'b1;
            end
        end

        // Outputs are silenced while reset is asserted, whatever the state
        if (rst) begin
            w_stall        = STALL_NONE;
            w_ifid_discard = 1'b0;
            w_idex_discard = 1'b0;
            w_pc_redirect  = 1'b0;
            w_pc_target    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if ((w_stall != STALL_NONE) && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.IFID_discard_o = w_ifid_discard;
    assign bus.IDEX_discard_o = w_idex_discard;
    assign bus.pc_redirect_o  = w_pc_redirect;
    assign bus.pc_target_o    = w_pc_target;
    assign bus.stall_cycles_o = r_stall_cycles;

endmodule : pipe_ctrl
`default_nettype wire
